// File: rtl/bomb_pkg.sv
// Shared types and widths for the bomb-game controller and its checker link.
package bomb_pkg;

  localparam int unsigned TIME_W = 7;
  localparam int unsigned TRY_W  = 3;
  localparam int unsigned PSW_W  = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_ARMED    = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DEFUSED  = 3'd4,
    ST_EXPLODED = 3'd5
  } state_t;

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// Link between the game sequencer (master) and the password checker (slave).
interface bomb_game_ctrl_if;
  import bomb_pkg::*;

  logic             check_en;
  logic             check_rst_n;
  logic [PSW_W-1:0] psw;
  logic             check_pass;

  modport master (output check_en, output check_rst_n, output psw, input check_pass);
  modport slave  (input check_en, input check_rst_n, input psw, output check_pass);
endinterface

// File: rtl/bomb_game_ctrl_tick.sv
// Seconds prescaler: one-cycle tick every CLK_HZ enabled cycles; clr restarts the count.
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);
endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb-game sequencer: latches the password, runs the countdown and try counter,
// and decides defused/exploded from the checker's sticky pass flag.
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 1000,
  parameter int unsigned TIME_S    = 60,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_start,
  input  logic              btn_confirm,
  input  logic [PSW_W-1:0]  SW,
  bomb_game_ctrl_if.master  chk,
  output logic              armed,
  output logic              defused,
  output logic              exploded,
  output logic [TIME_W-1:0] time_left,
  output logic [TRY_W-1:0]  tries_left
);
  localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(TIME_S);
  localparam logic [TRY_W-1:0]  TRY_INIT  = TRY_W'(MAX_TRIES);

  state_t           state, state_n;
  logic             start_q, confirm_q;
  logic             start_ev, confirm_ev;
  logic             tick, tick_clr, tick_en, expire;
  logic [PSW_W-1:0] psw_q;

  assign start_ev   = btn_start & ~start_q;
  assign confirm_ev = btn_confirm & ~confirm_q;
  assign tick_en    = (state == ST_ARMED) || (state == ST_CHECK);
  assign tick_clr   = (state == ST_SETUP) && confirm_ev;
  // Expiry is the tick that takes the counter to zero, so it is known a cycle early.
  assign expire     = tick && (time_left <= TIME_W'(1));

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q   <= 1'b0;
      confirm_q <= 1'b0;
    end else begin
      start_q   <= btn_start;
      confirm_q <= btn_confirm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psw_q      <= '0;
      time_left  <= TIME_INIT;
      tries_left <= TRY_INIT;
    end else begin
      if (tick_clr) begin
        psw_q      <= SW;
        time_left  <= TIME_INIT;
        tries_left <= TRY_INIT;
      end
      if (tick && (time_left != '0)) time_left <= time_left - 1'b1;
      if ((state == ST_CHECK) && !chk.check_pass && (tries_left != '0))
        tries_left <= tries_left - 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start_ev) state_n = ST_SETUP;
      ST_SETUP: if (confirm_ev) state_n = ST_ARMED;
      ST_ARMED: begin
        if (expire)          state_n = ST_EXPLODED;
        else if (confirm_ev) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if (chk.check_pass)                             state_n = ST_DEFUSED;
        else if ((tries_left <= TRY_W'(1)) || expire)   state_n = ST_EXPLODED;
        else                                            state_n = ST_ARMED;
      end
      ST_DEFUSED, ST_EXPLODED: if (start_ev) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    armed           = (state == ST_ARMED) || (state == ST_CHECK);
    defused         = (state == ST_DEFUSED);
    exploded        = (state == ST_EXPLODED);
    chk.check_en    = (state == ST_ARMED) || (state == ST_CHECK);
    chk.check_rst_n = (state != ST_IDLE) && (state != ST_SETUP);
    chk.psw         = psw_q;
  end
endmodule
